// File: rtl/dsp_post_addsub_preg_pkg.sv
// ---------------------------------------------------------------------------
// dsp48a1_pkg : X/Z mux codes, OPMODE bit indices and widths   rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dsp48a1_pkg;

    localparam int P_W     = 48;
    localparam int M_W     = 36;
    localparam int OPM_CIN = 5;
    localparam int OPM_SUB = 7;

    localparam logic [1:0] X_ZERO = 2'd0;
    localparam logic [1:0] X_M    = 2'd1;
    localparam logic [1:0] X_P    = 2'd2;
    localparam logic [1:0] X_DAB  = 2'd3;

    localparam logic [1:0] Z_ZERO = 2'd0;
    localparam logic [1:0] Z_PCIN = 2'd1;
    localparam logic [1:0] Z_P    = 2'd2;
    localparam logic [1:0] Z_C    = 2'd3;

    function automatic logic [P_W-1:0] sext_m(input logic [M_W-1:0] m);
        return {{(P_W-M_W){m[M_W-1]}}, m};
    endfunction

endpackage

`default_nettype wire

// File: rtl/dsp_post_addsub_preg_if.sv
// ---------------------------------------------------------------------------
// dsp_post_addsub_preg_if : operand/result bundle of the post-adder stage   rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface dsp_post_addsub_preg_if;
    import dsp48a1_pkg::*;

    logic             ce_cin;
    logic             ce_p;
    logic             in_valid;
    logic [7:0]       opmode;
    logic [M_W-1:0]   m_in;
    logic [P_W-1:0]   dab_in;
    logic [P_W-1:0]   c_in;
    logic [P_W-1:0]   pcin;
    logic             carryin;
    logic             clr_ovf;
    logic [P_W-1:0]   p_out;
    logic [P_W-1:0]   pcout;
    logic             carryout;
    logic             carryoutf;
    logic             out_valid;
    logic             ovf;

    modport master (
        output ce_cin, ce_p, in_valid, opmode, m_in, dab_in, c_in, pcin, carryin, clr_ovf,
        input  p_out, pcout, carryout, carryoutf, out_valid, ovf
    );

    modport slave (
        input  ce_cin, ce_p, in_valid, opmode, m_in, dab_in, c_in, pcin, carryin, clr_ovf,
        output p_out, pcout, carryout, carryoutf, out_valid, ovf
    );

endinterface

`default_nettype wire

// File: rtl/dsp_post_addsub_preg_addsub.sv
// ---------------------------------------------------------------------------
// dsp_post_addsub : combinational X/Z mux and 49-bit post add/subtract   rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dsp_post_addsub
    import dsp48a1_pkg::*;
(
    input  logic [1:0]     x_sel,
    input  logic [1:0]     z_sel,
    input  logic           sub,
    input  logic           cin,
    input  logic [M_W-1:0] m_in,
    input  logic [P_W-1:0] dab_in,
    input  logic [P_W-1:0] c_in,
    input  logic [P_W-1:0] pcin,
    input  logic [P_W-1:0] p_fb,
    output logic [P_W:0]   r,
    output logic           overflow
);

    logic [P_W-1:0] x;
    logic [P_W-1:0] z;

    always_comb begin
        x = '0;
        case (x_sel)
            X_M:     x = sext_m(m_in);
            X_P:     x = p_fb;
            X_DAB:   x = dab_in;
            default: x = '0;
        endcase
    end

    always_comb begin
        z = '0;
        case (z_sel)
            Z_PCIN:  z = pcin;
            Z_P:     z = p_fb;
            Z_C:     z = c_in;
            default: z = '0;
        endcase
    end

    // Z - (X + cin) is formed as Z + ~X + ~cin, so bit 48 reads as not-borrow.
    assign r = sub ? ({1'b0, z} + {1'b0, ~x} + {{P_W{1'b0}}, ~cin})
                   : ({1'b0, z} + {1'b0,  x} + {{P_W{1'b0}},  cin});

    assign overflow = (sub ? (x[P_W-1] != z[P_W-1]) : (x[P_W-1] == z[P_W-1]))
                      && (r[P_W-1] != z[P_W-1]);

endmodule

`default_nettype wire

// File: rtl/dsp_post_addsub_preg.sv
// ---------------------------------------------------------------------------
// dsp_post_addsub_preg : DSP48A1 post-adder with P/CARRYOUT registers   rev 1.0
// Optional sticky signed-overflow flag enabled by macro DSP_OVF_STICKY_EN.
// ---------------------------------------------------------------------------
`default_nettype none

module dsp_post_addsub_preg
    import dsp48a1_pkg::*;
#(
    parameter int    PREG        = 1,
    parameter int    CARRYINREG  = 1,
    parameter int    CARRYOUTREG = 1,
    parameter string CARRYINSEL  = "OPMODE5"
) (
    input  logic                  clk,
    input  logic                  rst,
    dsp_post_addsub_preg_if.slave bus
);

    logic           cin_sel;
    logic           cin_use;
    logic [P_W-1:0] p_reg;
    logic           carry_reg;
    logic           valid_reg;
    logic [P_W:0]   r;
    logic           ovf_now;
    logic           unused_sink;

    if (CARRYINSEL == "OPMODE5") begin : g_cin_opmode
        assign cin_sel = bus.opmode[OPM_CIN];
    end else if (CARRYINSEL == "CARRYIN") begin : g_cin_port
        assign cin_sel = bus.carryin;
    end else begin : g_cin_bad
        $error("dsp_post_addsub_preg: CARRYINSEL must be \"OPMODE5\" or \"CARRYIN\"");
        assign cin_sel = 1'b0;
    end

    // The carry-in register lines up with the upstream M register.
    if (CARRYINREG != 0) begin : g_cyi_reg
        logic cyi;
        always_ff @(posedge clk or posedge rst) begin
            if (rst)             cyi <= 1'b0;
            else if (bus.ce_cin) cyi <= cin_sel;
        end
        assign cin_use = cyi;
    end else begin : g_cyi_bypass
        assign cin_use = cin_sel;
    end

    dsp_post_addsub u_addsub (
        .x_sel    (bus.opmode[1:0]),
        .z_sel    (bus.opmode[3:2]),
        .sub      (bus.opmode[OPM_SUB]),
        .cin      (cin_use),
        .m_in     (bus.m_in),
        .dab_in   (bus.dab_in),
        .c_in     (bus.c_in),
        .pcin     (bus.pcin),
        .p_fb     (p_reg),
        .r        (r),
        .overflow (ovf_now)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_reg     <= '0;
            carry_reg <= 1'b0;
            valid_reg <= 1'b0;
        end else if (bus.ce_p) begin
            p_reg     <= r[P_W-1:0];
            carry_reg <= r[P_W];
            valid_reg <= bus.in_valid;
        end
    end

    // Feedback always comes from p_reg; PREG only chooses what is presented.
    if (PREG != 0) begin : g_p_registered
        assign bus.p_out     = p_reg;
        assign bus.out_valid = valid_reg;
    end else begin : g_p_direct
        assign bus.p_out     = rst ? '0 : r[P_W-1:0];
        assign bus.out_valid = bus.in_valid & ~rst;
    end

    if (CARRYOUTREG != 0) begin : g_co_registered
        assign bus.carryout = carry_reg;
    end else begin : g_co_direct
        assign bus.carryout = r[P_W] & ~rst;
    end

    assign bus.pcout     = bus.p_out;
    assign bus.carryoutf = bus.carryout;

`ifdef DSP_OVF_STICKY_EN
    logic ovf_reg;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      ovf_reg <= 1'b0;
        else if (bus.ce_p && ovf_now) ovf_reg <= 1'b1;
        else if (bus.clr_ovf)         ovf_reg <= 1'b0;
    end
    assign bus.ovf = ovf_reg;
    assign unused_sink = ^{bus.opmode[6], bus.opmode[5], bus.opmode[4], bus.carryin,
                           bus.ce_cin, valid_reg, carry_reg};
`else
    assign bus.ovf = 1'b0;
    assign unused_sink = ^{bus.opmode[6], bus.opmode[5], bus.opmode[4], bus.carryin,
                           bus.ce_cin, valid_reg, carry_reg, ovf_now, bus.clr_ovf};
`endif

endmodule

`default_nettype wire

// File: tb/tb_dsp_post_addsub_preg.sv
// ---------------------------------------------------------------------------
// tb_dsp_post_addsub_preg : scoreboard bench, registered and direct builds   rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dsp_post_addsub_preg;
    import dsp48a1_pkg::*;

    localparam logic [63:0] MASK48 = 64'hFFFF_FFFF_FFFF;
    localparam longint      TWO47  = 64'sd140737488355328;
`ifdef DSP_OVF_STICKY_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    typedef struct packed {
        logic [47:0] p;
        logic        c;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dsp_post_addsub_preg_if ifa ();
    dsp_post_addsub_preg_if ifb ();

    dsp_post_addsub_preg #(.PREG(1), .CARRYINREG(1), .CARRYOUTREG(1), .CARRYINSEL("OPMODE5"))
        dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    dsp_post_addsub_preg #(.PREG(0), .CARRYINREG(0), .CARRYOUTREG(0), .CARRYINSEL("CARRYIN"))
        dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    int          checks   = 0;
    int          failures = 0;
    res_t        qa[$];
    res_t        qb[$];
    logic [63:0] mp[2];
    logic        movf[2];
    logic        ovf_exp[2];
    logic        mcyi;
    logic [47:0] held_a    = '0;
    logic        last_ce_p = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference arithmetic on plain integers.
    function automatic logic [63:0] sel_x(input logic [1:0] s, input logic [35:0] m,
                                          input logic [63:0] p, input logic [47:0] dab);
        case (s)
            2'd0:    return 64'd0;
            2'd1:    return 64'(longint'($signed(m))) & MASK48;
            2'd2:    return p;
            default: return {16'd0, dab};
        endcase
    endfunction

    function automatic logic [63:0] sel_z(input logic [1:0] s, input logic [47:0] pc,
                                          input logic [63:0] p, input logic [47:0] c);
        case (s)
            2'd0:    return 64'd0;
            2'd1:    return {16'd0, pc};
            2'd2:    return p;
            default: return {16'd0, c};
        endcase
    endfunction

    function automatic logic [63:0] alu(input logic sub, input logic [63:0] x,
                                        input logic [63:0] z, input logic cin);
        if (sub) return 64'h1_0000_0000_0000 + z - x - 64'(cin);
        else     return z + x + 64'(cin);
    endfunction

    function automatic logic ovf_cond(input logic sub, input logic [63:0] x,
                                      input logic [63:0] z, input logic cin);
        longint xs, zs, ideal;
        xs    = x[47] ? longint'(x) - 2 * TWO47 : longint'(x);
        zs    = z[47] ? longint'(z) - 2 * TWO47 : longint'(z);
        ideal = sub ? zs - xs - longint'(cin) : zs + xs + longint'(cin);
        return (ideal >= TWO47) || (ideal < -TWO47);
    endfunction

    task automatic drive(input logic iv, input logic [7:0] op, input logic [35:0] m,
                         input logic [47:0] dab, input logic [47:0] c, input logic [47:0] pc,
                         input logic ci, input logic cep, input logic cecin, input logic clr);
        ifa.in_valid = iv; ifa.opmode = op; ifa.m_in = m; ifa.dab_in = dab; ifa.c_in = c;
        ifa.pcin = pc; ifa.carryin = ci; ifa.ce_p = cep; ifa.ce_cin = cecin; ifa.clr_ovf = clr;
        ifb.in_valid = iv; ifb.opmode = op; ifb.m_in = m; ifb.dab_in = dab; ifb.c_in = c;
        ifb.pcin = pc; ifb.carryin = ci; ifb.ce_p = cep; ifb.ce_cin = cecin; ifb.clr_ovf = clr;
    endtask

    task automatic step(input logic iv, input logic [7:0] op, input logic [35:0] m,
                        input logic [47:0] dab, input logic [47:0] c, input logic [47:0] pc,
                        input logic ci, input logic cep, input logic cecin, input logic clr);
        logic [63:0] x, z, v;
        logic        cin;
        @(posedge clk);
        #1;
        drive(iv, op, m, dab, c, pc, ci, cep, cecin, clr);
        for (int k = 0; k < 2; k++) begin
            ovf_exp[k] = movf[k];
            cin = (k == 0) ? mcyi : ci;
            x   = sel_x(op[1:0], m, mp[k], dab);
            z   = sel_z(op[3:2], pc, mp[k], c);
            v   = alu(op[7], x, z, cin);
            if (k == 0 && iv && cep) qa.push_back('{p: v[47:0], c: v[48]});
            if (k == 1 && iv)        qb.push_back('{p: v[47:0], c: v[48]});
            if (cep && ovf_cond(op[7], x, z, cin)) movf[k] = 1'b1;
            else if (clr)                          movf[k] = 1'b0;
            if (cep) mp[k] = v & MASK48;
        end
        if (cecin) mcyi = op[5];
        #1;
    endtask

    task automatic idle(input logic cep);
        step(1'b0, 8'h00, 36'h0, 48'h0, 48'h0, 48'h0, 1'b0, cep, 1'b1, 1'b0);
    endtask

    task automatic clear_model();
        qa.delete();
        qb.delete();
        for (int k = 0; k < 2; k++) begin
            mp[k] = '0; movf[k] = 1'b0; ovf_exp[k] = 1'b0;
        end
        mcyi = 1'b0;
    endtask

    // Reset lands between clock edges; outputs must clear without waiting for one.
    task automatic do_reset();
        @(posedge clk);
        #1;
        drive(1'b0, 8'h00, 36'h0, 48'h0, 48'h0, 48'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        ovf_exp[0] = movf[0];
        ovf_exp[1] = movf[1];
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_a_p_out",     ifa.p_out,     0);
        check("rst_a_out_valid", ifa.out_valid, 0);
        check("rst_a_carryout",  ifa.carryout,  0);
        check("rst_a_ovf",       ifa.ovf,       0);
        check("rst_b_p_out",     ifb.p_out,     0);
        check("rst_b_out_valid", ifb.out_valid, 0);
        clear_model();
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    always @(posedge clk) last_ce_p <= ifa.ce_p;

    always @(negedge clk) begin
        res_t e;
        if (!rst) begin
            if (ifa.out_valid) begin
                if (!last_ce_p) begin
                    check("a_hold", ifa.p_out, held_a);
                end else if (qa.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL a_unexpected: out_valid=1 p_out=%0h, none expected", ifa.p_out);
                end else begin
                    e = qa.pop_front();
                    check("a_p_out",     ifa.p_out,     e.p);
                    check("a_pcout",     ifa.pcout,     e.p);
                    check("a_carryout",  ifa.carryout,  e.c);
                    check("a_carryoutf", ifa.carryoutf, e.c);
                    held_a = e.p;
                end
            end
            if (ifb.out_valid) begin
                if (qb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL b_unexpected: out_valid=1 p_out=%0h, none expected", ifb.p_out);
                end else begin
                    e = qb.pop_front();
                    check("b_p_out",     ifb.p_out,     e.p);
                    check("b_pcout",     ifb.pcout,     e.p);
                    check("b_carryout",  ifb.carryout,  e.c);
                    check("b_carryoutf", ifb.carryoutf, e.c);
                end
            end
            check("a_ovf", ifa.ovf, OVF_ON ? ovf_exp[0] : 1'b0);
            check("b_ovf", ifb.ovf, OVF_ON ? ovf_exp[1] : 1'b0);
        end
    end

    initial begin
        logic [7:0]  op;
        logic [35:0] m;
        logic [47:0] dab, c, pc;

        clear_model();
        drive(1'b0, 8'h00, 36'h0, 48'h0, 48'h0, 48'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        #12;
        check("init_a_p_out",     ifa.p_out,     0);
        check("init_a_out_valid", ifa.out_valid, 0);
        check("init_a_ovf",       ifa.ovf,       0);
        #10;
        rst = 1'b0;

        idle(1'b1);
        // X=M, Z=C: 10 + (-3)
        step(1'b1, 8'h0D, 36'hF_FFFF_FFFD, 48'h0, 48'd10, 48'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("dir_add_b_p",  ifb.p_out,    7);
        check("dir_add_b_co", ifb.carryout, 1);
        idle(1'b0);
        check("dir_add_a_p",  ifa.p_out,     7);
        check("dir_add_a_co", ifa.carryout,  1);
        check("dir_add_a_v",  ifa.out_valid, 1);

        do_reset();
        for (int k = 1; k <= 4; k++) begin
            step(1'b1, 8'h09, 36'd5, 48'h0, 48'h0, 48'h0, 1'b0, 1'b1, 1'b1, 1'b0);
            check("acc_b_p", ifb.p_out, 64'(5 * k));
            if (k > 1) check("acc_a_p", ifa.p_out, 64'(5 * (k - 1)));
        end
        idle(1'b0);
        check("acc_a_final", ifa.p_out, 20);

        step(1'b1, 8'h8D, 36'd6, 48'h0, 48'd4, 48'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("sub_b_p",  ifb.p_out,    48'hFFFF_FFFF_FFFE);
        check("sub_b_co", ifb.carryout, 0);
        idle(1'b0);
        check("sub_a_p",  ifa.p_out,    48'hFFFF_FFFF_FFFE);
        check("sub_a_co", ifa.carryout, 0);

        step(1'b1, 8'h03, 36'h0, 48'hFFFF_FFFF_FFFF, 48'h0, 48'h0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("cyin_b_p",  ifb.p_out,    0);
        check("cyin_b_co", ifb.carryout, 1);
        idle(1'b1);

        step(1'b1, 8'h0D, 36'd1, 48'h0, 48'h7FFF_FFFF_FFFF, 48'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(1'b0);
        check("ovf_a_p",    ifa.p_out, 48'h8000_0000_0000);
        check("ovf_a_set",  ifa.ovf,   OVF_ON);
        check("ovf_b_set",  ifb.ovf,   OVF_ON);
        idle(1'b0);
        check("ovf_a_held", ifa.ovf,   OVF_ON);
        step(1'b0, 8'h00, 36'h0, 48'h0, 48'h0, 48'h0, 1'b0, 1'b1, 1'b1, 1'b1);
        idle(1'b0);
        check("ovf_a_clr",  ifa.ovf,   0);
        check("ovf_b_clr",  ifb.ovf,   0);

        for (int i = 0; i < 400; i++) begin
            op  = 8'($urandom);
            m   = ($urandom_range(0, 3) == 0) ? 36'($urandom_range(0, 15)) : 36'({$urandom, $urandom});
            dab = 48'({$urandom, $urandom});
            c   = ($urandom_range(0, 3) == 0) ? 48'h7FFF_FFFF_FFFF : 48'({$urandom, $urandom});
            pc  = 48'({$urandom, $urandom});
            step($urandom_range(0, 9) < 8, op, m, dab, c, pc, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0);
        end

        // Reset mid-accumulation: the first feedback afterwards must read zero.
        do_reset();
        step(1'b1, 8'h09, 36'd7, 48'h0, 48'h0, 48'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("post_rst_b_p", ifb.p_out, 7);
        idle(1'b1);
        check("post_rst_a_p", ifa.p_out, 7);

        for (int i = 0; i < 3; i++) idle(1'b1);
        check("qa_drained", qa.size(), 0);
        check("qb_drained", qb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
